// File: rtl/tight_acc_matmul_seq_if.sv
// Command/response port between the core and the matrix-multiply accelerator.
// The core drives the master side; the accelerator sits on the slave side.
interface tight_acc_matmul_seq_if;
    logic        cmd_val;
    logic        busy;
    logic [5:0]  cmd_opcode;
    logic [63:0] cmd_config_data;
    logic        resp_val;
    logic        resp_rdy;
    logic [63:0] resp_data;

    modport master (
        output cmd_val, cmd_opcode, cmd_config_data, resp_rdy,
        input  busy, resp_val, resp_data
    );

    modport slave (
        input  cmd_val, cmd_opcode, cmd_config_data, resp_rdy,
        output busy, resp_val, resp_data
    );
endinterface

// File: rtl/tight_acc_matmul_seq.sv
// Matrix-multiply accelerator: A and B are streamed in by command.
// R = A x B is computed with one MAC per cycle, and R is read back element by element.
module tight_acc_matmul_seq #(
    parameter int N     = 4,
    parameter int DW    = 32,
    parameter int ACC_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tight_acc_matmul_seq_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int NW = $clog2(N + 1);
    localparam int PW = 2 * DW;

    localparam logic [5:0] OP_INIT  = 6'd10;
    localparam logic [5:0] OP_FILLA = 6'd11;
    localparam logic [5:0] OP_FILLB = 6'd12;
    localparam logic [5:0] OP_READ  = 6'd13;
    localparam logic [5:0] OP_CFG   = 6'd14;
    localparam logic [5:0] OP_MULT  = 6'd25;

    typedef enum logic [1:0] {IDLE, COMPUTE, RESP} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic [63:0]       respData_q, respData_d;
    logic [NW-1:0]     dimN_q;
    logic [IW-1:0]     rowA_q, colA_q, rowB_q, colB_q, rowR_q, colR_q;
    logic [IW-1:0]     idxI_q, idxJ_q, idxK_q;
    logic [ACC_W-1:0]  acc_q;
    logic [DW-1:0]     matA_q [N][N];
    logic [DW-1:0]     matB_q [N][N];
    logic [ACC_W-1:0]  matR_q [N][N];

    logic              accept;
    logic [NW-1:0]     lastIdx;
    logic [7:0]        cfgRaw;
    logic [NW-1:0]     cfgN;
    logic [63:0]       macCount;
    logic [PW-1:0]     prod;
    logic [ACC_W-1:0]  macSum;
    logic              kLast, jLast, iLast, macDone;
    logic [63:0]       readVal;

    // Row-major pointer step over the active n x n region, wrapping to (0,0).
    function automatic logic [2*IW-1:0] advance(input logic [IW-1:0] row,
                                                input logic [IW-1:0] col,
                                                input logic [NW-1:0] last);
        if (NW'(col) == last) begin
            if (NW'(row) == last) return '0;
            return {row + IW'(1), {IW{1'b0}}};
        end
        return {row, col + IW'(1)};
    endfunction

    assign accept   = bus.cmd_val & ~busy_q;
    assign lastIdx  = dimN_q - NW'(1);
    assign cfgRaw   = bus.cmd_config_data[7:0];
    assign cfgN     = (cfgRaw == 8'd0 || cfgRaw > 8'(N)) ? NW'(N) : cfgRaw[NW-1:0];
    assign macCount = 64'(dimN_q) * 64'(dimN_q) * 64'(dimN_q);
    assign prod     = PW'(matA_q[idxI_q][idxK_q]) * PW'(matB_q[idxK_q][idxJ_q]);
    assign macSum   = acc_q + ACC_W'(prod);
    assign kLast    = (NW'(idxK_q) == lastIdx);
    assign jLast    = (NW'(idxJ_q) == lastIdx);
    assign iLast    = (NW'(idxI_q) == lastIdx);
    assign macDone  = kLast & jLast & iLast;
    assign readVal  = 64'(matR_q[rowR_q][colR_q]);

    generate
        if (DW < 64) begin : g_unusedPayload
            logic unusedPayload;
            assign unusedPayload = ^bus.cmd_config_data[63:DW];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            respData_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            respData_q <= respData_d;
        end
    end

    // Response payload is captured once at acceptance and held through RESP.
    always_comb begin
        state_d    = state_q;
        respData_d = respData_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RESP;
                    case (bus.cmd_opcode)
                        OP_INIT, OP_FILLA, OP_FILLB: respData_d = '0;
                        OP_CFG:  respData_d = 64'(cfgN);
                        OP_READ: respData_d = readVal;
                        OP_MULT: begin
                            state_d    = COMPUTE;
                            respData_d = macCount;
                        end
                        default: respData_d = '1;
                    endcase
                end
            end
            COMPUTE: if (macDone) state_d = RESP;
            RESP:    if (bus.resp_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.busy      = busy_q;
    assign bus.resp_val  = (state_q == RESP);
    assign bus.resp_data = respData_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dimN_q <= NW'(N);
            {rowA_q, colA_q, rowB_q, colB_q, rowR_q, colR_q} <= '0;
            {idxI_q, idxJ_q, idxK_q} <= '0;
            acc_q <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    matA_q[r][c] <= '0;
                    matB_q[r][c] <= '0;
                    matR_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            case (bus.cmd_opcode)
                OP_INIT: begin
                    {rowA_q, colA_q, rowB_q, colB_q, rowR_q, colR_q} <= '0;
                    {idxI_q, idxJ_q, idxK_q} <= '0;
                    acc_q <= '0;
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            matA_q[r][c] <= '0;
                            matB_q[r][c] <= '0;
                            matR_q[r][c] <= '0;
                        end
                    end
                end
                OP_FILLA: begin
                    matA_q[rowA_q][colA_q] <= bus.cmd_config_data[DW-1:0];
                    {rowA_q, colA_q} <= advance(rowA_q, colA_q, lastIdx);
                end
                OP_FILLB: begin
                    matB_q[rowB_q][colB_q] <= bus.cmd_config_data[DW-1:0];
                    {rowB_q, colB_q} <= advance(rowB_q, colB_q, lastIdx);
                end
                OP_CFG: begin
                    dimN_q <= cfgN;
                    {rowA_q, colA_q, rowB_q, colB_q, rowR_q, colR_q} <= '0;
                end
                OP_READ: {rowR_q, colR_q} <= advance(rowR_q, colR_q, lastIdx);
                OP_MULT: begin
                    {idxI_q, idxJ_q, idxK_q} <= '0;
                    acc_q <= '0;
                end
                default: ;
            endcase
        end else if (state_q == COMPUTE) begin
            // k is innermost: finishing a dot product commits R[i][j] and restarts acc.
            if (kLast) begin
                matR_q[idxI_q][idxJ_q] <= macSum;
                acc_q  <= '0;
                idxK_q <= '0;
                if (jLast) begin
                    idxJ_q <= '0;
                    idxI_q <= iLast ? '0 : idxI_q + IW'(1);
                end else begin
                    idxJ_q <= idxJ_q + IW'(1);
                end
            end else begin
                acc_q  <= macSum;
                idxK_q <= idxK_q + IW'(1);
            end
        end
    end
endmodule
